// File: rtl/count_sequencer.sv
// rtl/count_sequencer.sv - run-control sequencer for an external counter with enable
//
// Purpose:
//   Prescales clk into count ticks and drives the enable and clear of an
//   external synchronous binary counter. At the programmed terminal value it
//   either stops (one-shot, state DONE) or clears the counter and keeps
//   running (auto-reload).
//
// Ports:
//   clk          in   clock, rising edge
//   rst          in   synchronous active-high reset
//   start        in   start from IDLE/DONE, resume from PAUSE
//   stop         in   pause request while running
//   clr          in   abort to IDLE and clear the counter
//   mode_reload  in   1 = auto-reload at limit, 0 = one-shot
//   presc        in   prescaler reload value, tick period = presc+1 clocks
//   limit        in   terminal count value
//   cnt_val      in   current value of the external counter
//   cnt_ena      out  counter enable, one cycle per non-terminal tick
//   cnt_clr      out  counter clear
//   tc           out  terminal-count pulse
//   busy         out  state is RUN or PAUSE
//   done         out  state is DONE
module count_sequencer #(
  parameter int Dwidth = 4,
  parameter int Pwidth = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              clr,
  input  logic              mode_reload,
  input  logic [Pwidth-1:0] presc,
  input  logic [Dwidth-1:0] limit,
  input  logic [Dwidth-1:0] cnt_val,
  output logic              cnt_ena,
  output logic              cnt_clr,
  output logic              tc,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic [Pwidth-1:0] psc, psc_nxt;
  logic [Pwidth-1:0] presc_sh;
  logic [Dwidth-1:0] limit_sh;
  logic              mode_sh;

  logic start_acc;
  logic run_act;
  logic tick;
  logic at_lim;

  // Decodes shared by next-state and output logic. Priority rst > clr > stop
  // > start is folded in here so a suppressed command can never leak a tick
  // or a clear.
  always_comb begin
    start_acc = ((state == IDLE) || (state == DONE)) && start && !stop && !clr && !rst;
    run_act   = (state == RUN) && !stop && !clr && !rst;
    tick      = run_act && (psc == presc_sh);
    at_lim    = (cnt_val == limit_sh);
  end

  // State register, prescaler and shadow configuration.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      psc      <= '0;
      presc_sh <= '0;
      limit_sh <= '0;
      mode_sh  <= 1'b0;
    end else begin
      state <= state_nxt;
      psc   <= psc_nxt;
      if (start_acc) begin
        presc_sh <= presc;
        limit_sh <= limit;
        mode_sh  <= mode_reload;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    psc_nxt   = psc;
    if (clr) begin
      state_nxt = IDLE;
      psc_nxt   = '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start_acc) begin
            state_nxt = RUN;
            psc_nxt   = '0;
          end
        end
        RUN: begin
          if (stop) begin
            state_nxt = PAUSE;
          end else if (tick) begin
            psc_nxt = '0;
            if (at_lim && !mode_sh) state_nxt = DONE;
          end else begin
            psc_nxt = psc + 1'b1;
          end
        end
        PAUSE: begin
          // Resume keeps the prescaler phase and the counter contents.
          if (start && !stop) state_nxt = RUN;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Output decode. A terminal tick never enables the counter, so cnt_ena and
  // cnt_clr stay mutually exclusive.
  always_comb begin
    cnt_ena = tick && !at_lim;
    tc      = tick && at_lim;
    cnt_clr = rst || clr || start_acc || (tick && at_lim && mode_sh);
    busy    = (state == RUN) || (state == PAUSE);
    done    = (state == DONE);
  end

endmodule

// File: tb/tb_count_sequencer.sv
// tb/tb_count_sequencer.sv - directed vector bench for count_sequencer
module tb_count_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       clr = 1'b0;
  logic       mode_reload = 1'b0;
  logic [7:0] presc = 8'd0;
  logic [3:0] limit = 4'd0;
  logic [3:0] cnt = 4'd0;
  logic       cnt_ena, cnt_clr, tc, busy, done;

  int pass_cnt = 0;
  int total_cnt = 0;

  count_sequencer #(.Dwidth(4), .Pwidth(8)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clr(clr),
    .mode_reload(mode_reload), .presc(presc), .limit(limit), .cnt_val(cnt),
    .cnt_ena(cnt_ena), .cnt_clr(cnt_clr), .tc(tc), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // exp bits: {cnt_ena, cnt_clr, tc, busy, done}; cv is the counter value on
  // the first repetition and advances by one per repetition that expects cnt_ena.
  typedef struct {
    logic       st, sp, cl, md;
    logic [7:0] pr;
    logic [3:0] li;
    int         rep;
    logic [4:0] ex;
    logic [3:0] cv;
  } vec_t;

  vec_t tbl[$];

  function automatic void v(input logic st, sp, cl, md, input int pr, li, rep,
                            input logic [4:0] ex, input int cv);
    vec_t e;
    e.st = st; e.sp = sp; e.cl = cl; e.md = md;
    e.pr = pr[7:0]; e.li = li[3:0]; e.rep = rep; e.ex = ex; e.cv = cv[3:0];
    tbl.push_back(e);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  task automatic drive(input logic st, sp, cl, md, input int pr, li);
    start = st; stop = sp; clr = cl; mode_reload = md;
    presc = pr[7:0]; limit = li[3:0];
  endtask

  // External counter model: samples enable/clear now (away from the edge),
  // applies them just after the next rising edge.
  task automatic advance();
    logic s_ena, s_clr;
    s_ena = cnt_ena;
    s_clr = cnt_clr;
    @(posedge clk);
    #1;
    if (s_clr) cnt = 4'd0;
    else if (s_ena) cnt = cnt + 4'd1;
  endtask

  initial begin
    logic [3:0] exc;
    int n_ena, seen, cnt_at;

    // T1: presc=0, limit=5, one-shot
    v(1,0,0,0, 0,5, 1, 5'b01000, 0);
    v(0,0,0,0, 0,5, 5, 5'b10010, 0);
    v(0,0,0,0, 0,5, 1, 5'b00110, 5);
    v(0,0,0,0, 0,5, 1, 5'b00001, 5);
    // T6: limit=0 from DONE
    v(1,0,0,0, 0,0, 1, 5'b01001, 5);
    v(0,0,0,0, 0,0, 1, 5'b00110, 0);
    v(0,0,0,0, 0,0, 1, 5'b00001, 0);
    // T3: presc=0, limit=3, reload
    v(1,0,0,1, 0,3, 1, 5'b01001, 0);
    v(0,0,0,1, 0,3, 3, 5'b10010, 0);
    v(0,0,0,1, 0,3, 1, 5'b01110, 3);
    v(0,0,0,1, 0,3, 3, 5'b10010, 0);
    v(0,0,0,1, 0,3, 1, 5'b01110, 3);
    v(0,0,0,1, 0,3, 1, 5'b10010, 0);
    // T5: start+stop+clr together in RUN
    v(1,1,1,1, 0,3, 1, 5'b01010, 1);
    v(0,0,0,1, 0,3, 1, 5'b00000, 0);
    // T5: limit input 7 -> 2 mid-run, shadow stays 7
    v(1,0,0,0, 0,7, 1, 5'b01000, 0);
    v(0,0,0,0, 0,7, 1, 5'b10010, 0);
    v(0,0,0,0, 0,2, 3, 5'b10010, 1);
    v(1,1,1,0, 0,2, 1, 5'b01010, 4);
    v(0,0,0,0, 0,2, 1, 5'b00000, 0);
    // T2: presc=3, limit=2, one-shot
    v(1,0,0,0, 3,2, 1, 5'b01000, 0);
    v(0,0,0,0, 3,2, 3, 5'b00010, 0);
    v(0,0,0,0, 3,2, 1, 5'b10010, 0);
    v(0,0,0,0, 3,2, 3, 5'b00010, 1);
    v(0,0,0,0, 3,2, 1, 5'b10010, 1);
    v(0,0,0,0, 3,2, 3, 5'b00010, 2);
    v(0,0,0,0, 3,2, 1, 5'b00110, 2);
    v(0,0,0,0, 3,2, 1, 5'b00001, 2);
    // T4: presc=2, pause mid-period, resume keeps phase
    v(1,0,0,0, 2,9, 1, 5'b01001, 2);
    v(0,0,0,0, 2,9, 2, 5'b00010, 0);
    v(0,0,0,0, 2,9, 1, 5'b10010, 0);
    v(0,0,0,0, 2,9, 1, 5'b00010, 1);
    v(0,1,0,0, 2,9, 5, 5'b00010, 1);
    v(0,0,0,0, 2,9, 2, 5'b00010, 1);
    v(1,0,0,0, 2,9, 1, 5'b00010, 1);
    v(1,0,0,0, 2,9, 1, 5'b00010, 1);
    v(0,0,0,0, 2,9, 1, 5'b10010, 1);
    v(0,0,0,0, 2,9, 1, 5'b00010, 2);
    v(0,0,1,0, 2,9, 1, 5'b01010, 2);
    v(0,0,0,0, 2,9, 1, 5'b00000, 0);
    v(0,1,0,0, 2,9, 1, 5'b00000, 0);

    // Reset: hold rst across one edge, then check the reset outputs.
    @(negedge clk);
    advance();
    @(negedge clk);
    chk("reset outputs", {cnt_ena, cnt_clr, tc, busy, done}, 5'b01000);
    advance();
    rst = 1'b0;

    foreach (tbl[i]) begin
      exc = tbl[i].cv;
      for (int r = 0; r < tbl[i].rep; r++) begin
        drive(tbl[i].st, tbl[i].sp, tbl[i].cl, tbl[i].md, int'(tbl[i].pr), int'(tbl[i].li));
        @(negedge clk);
        chk($sformatf("vec%0d.%0d outputs", i, r), {cnt_ena, cnt_clr, tc, busy, done}, tbl[i].ex);
        chk($sformatf("vec%0d.%0d cnt_val", i, r), cnt, exc);
        if (tbl[i].ex[4]) exc = exc + 4'd1;
        advance();
      end
    end

    // Counter upset above limit: runs to wrap, reaches limit, then tc.
    drive(1,0,0,0, 0,3);
    @(negedge clk);
    chk("upset start", {cnt_ena, cnt_clr, tc, busy, done}, 5'b01000);
    advance();
    cnt = 4'd14;
    drive(0,0,0,0, 0,3);
    n_ena = 0; seen = 0; cnt_at = -1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (cnt_ena) n_ena++;
      if (tc) begin
        seen = 1;
        cnt_at = int'(cnt);
      end
      advance();
      if (seen != 0) break;
    end
    chk("upset tc seen", seen, 1);
    chk("upset ena count", n_ena, 5);
    chk("upset tc cnt_val", cnt_at, 3);
    @(negedge clk);
    chk("upset done", {busy, done}, 2'b01);
    advance();

    // Reset in the middle of a run: clear, no tc, back to IDLE.
    drive(1,0,0,0, 0,2);
    @(negedge clk);
    advance();
    drive(0,0,0,0, 0,2);
    @(negedge clk);
    advance();
    rst = 1'b1;
    @(negedge clk);
    chk("midrun rst ena/clr/tc", {cnt_ena, cnt_clr, tc}, 3'b010);
    advance();
    rst = 1'b0;
    @(negedge clk);
    chk("after rst outputs", {cnt_ena, cnt_clr, tc, busy, done}, 5'b00000);
    chk("after rst cnt_val", cnt, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
